// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, phase lengths and word geometry.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREP    = 3'd1,
        COLLECT = 3'd2,
        WRITE   = 3'd3,
        FLUSH   = 3'd4,
        RUN     = 3'd5
    } state_t;

    localparam int PREP_CYCLES    = 2;
    localparam int FLUSH_CYCLES   = 2;
    localparam int BYTES_PER_WORD = 4;

    function automatic int clampCount(input int requested, input int limit);
        return (requested > limit) ? limit : requested;
    endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs a byte stream into 32-bit words, first byte landing in the most significant lane.
module byte_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] byteIndex;

    // High in the cycle whose accepted byte completes the word, so the FSM can move on that edge.
    assign full = accept && (byteIndex == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            byteIndex <= '0;
            word      <= '0;
        end else if (clear) begin
            byteIndex <= '0;
            word      <= '0;
        end else if (accept) begin
            byteIndex <= byteIndex + 2'd1;
            word      <= {word[23:0], byteIn};
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams program bytes into CPU instruction memory while holding the CPU in reset around the load.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Abort,
    input  logic [CW-1:0] WordCount,
    input  logic [7:0]    ByteIn,
    input  logic          ByteValid,
    output logic          ByteReady,
    output logic          LoadInstructions,
    output logic [31:0]   Instruction,
    output logic [CW-1:0] LoadAddress,
    output logic          CPUReset,
    output logic          Busy,
    output logic          Done,
    output state_t        DebugState
);

    // Handshake: a byte transfers on a rising edge where ByteValid and ByteReady are both high;
    // ByteReady depends only on the state register, never on ByteValid.

    state_t        state;
    logic [CW-1:0] target;
    logic [CW-1:0] loadCount;
    logic [CW-1:0] nextCount;
    logic [1:0]    cycleCnt;
    logic          abortNow;
    logic          startNow;
    logic          accept;
    logic          packClear;
    logic          wordFull;
    logic [31:0]   packedWord;

    assign abortNow  = Abort && (state inside {PREP, COLLECT, WRITE});
    assign startNow  = Start && (state inside {IDLE, RUN});
    assign accept    = (state == COLLECT) && ByteValid && !Abort;
    assign packClear = abortNow || startNow || (state == WRITE);
    assign nextCount = loadCount + 1'b1;

    byte_packer uPacker (
        .clk     (clk),
        .Reset_n (Reset_n),
        .accept  (accept),
        .clear   (packClear),
        .byteIn  (ByteIn),
        .word    (packedWord),
        .full    (wordFull)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            target    <= '0;
            loadCount <= '0;
            cycleCnt  <= '0;
        end else if (abortNow) begin
            state    <= IDLE;
            cycleCnt <= '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (Start) begin
                        state     <= PREP;
                        target    <= CW'(clampCount(int'(WordCount), DEPTH));
                        loadCount <= '0;
                        cycleCnt  <= '0;
                    end
                end
                PREP: begin
                    if (cycleCnt == 2'(PREP_CYCLES - 1)) begin
                        cycleCnt <= '0;
                        state    <= (target != '0) ? COLLECT : FLUSH;
                    end else begin
                        cycleCnt <= cycleCnt + 2'd1;
                    end
                end
                COLLECT: begin
                    if (wordFull) state <= WRITE;
                end
                WRITE: begin
                    loadCount <= nextCount;
                    cycleCnt  <= '0;
                    state     <= (nextCount == target) ? FLUSH : COLLECT;
                end
                FLUSH: begin
                    if (cycleCnt == 2'(FLUSH_CYCLES - 1)) begin
                        cycleCnt <= '0;
                        state    <= RUN;
                    end else begin
                        cycleCnt <= cycleCnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode the registered state, so no input reaches an output combinationally.
    assign ByteReady        = (state == COLLECT);
    assign LoadInstructions = (state == WRITE);
    assign Instruction      = LoadInstructions ? packedWord : '0;
    assign LoadAddress      = LoadInstructions ? loadCount : '0;
    assign CPUReset         = state inside {IDLE, PREP, FLUSH};
    assign Busy             = state inside {PREP, COLLECT, WRITE, FLUSH};
    assign Done             = (state == RUN);
    assign DebugState       = state;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: expected writes are queued per load, a monitor pops them.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int CW    = 6;
    localparam int DEPTH = 32;
    localparam int W     = CW + 32;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic [CW-1:0] WordCount = '0;
    logic [7:0]    ByteIn = '0;
    logic          ByteValid = 1'b0;
    logic          ByteReady;
    logic          LoadInstructions;
    logic [31:0]   Instruction;
    logic [CW-1:0] LoadAddress;
    logic          CPUReset;
    logic          Busy;
    logic          Done;
    state_t        DebugState;

    always #5 clk = ~clk;

    program_loader #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk              (clk),
        .Reset_n          (Reset_n),
        .Start            (Start),
        .Abort            (Abort),
        .WordCount        (WordCount),
        .ByteIn           (ByteIn),
        .ByteValid        (ByteValid),
        .ByteReady        (ByteReady),
        .LoadInstructions (LoadInstructions),
        .Instruction      (Instruction),
        .LoadAddress      (LoadAddress),
        .CPUReset         (CPUReset),
        .Busy             (Busy),
        .Done             (Done),
        .DebugState       (DebugState)
    );

    logic [W-1:0] exp_q[$];
    logic [7:0]   stim[$];
    logic [7:0]   fixed_bytes [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected {address, word}.
    always @(negedge clk) begin
        if (LoadInstructions === 1'b1) begin
            pulse_cnt++;
            check("write_byte_ready", 64'(ByteReady), 64'd0);
            if (exp_q.size() == 0) check("unexpected_write", 64'({LoadAddress, Instruction}), 64'd0 - 64'd1);
            else check("write_data", 64'({LoadAddress, Instruction}), 64'(exp_q.pop_front()));
        end else begin
            check("idle_bus_zero", 64'({LoadAddress, Instruction}), 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, 64'({CPUReset, ByteReady, LoadInstructions, Busy, Done}), 64'b10000);
        check({tag, "_bus"}, 64'({LoadAddress, Instruction}), 64'd0);
    endtask

    task automatic do_start(input int n);
        WordCount = CW'(n);
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // Counts cycles with CPUReset and Busy both high until ByteReady (or Done) appears.
    task automatic count_busy_reset(input bit until_ready, output int c);
        int g = 0;
        c = 0;
        while (!(until_ready ? ByteReady : Done)) begin
            if (CPUReset && Busy) c++;
            step();
            g++;
            if (g > 200) begin
                check("wait_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    // mode 0: valid every cycle, 1: valid toggles 1,0,1,0, 2: random valid with stray Start pulses.
    task automatic stream(input int count, input int mode);
        int sent = 0;
        int guard = 0;
        bit phase = 1'b1;
        bit acc;
        while (sent < count) begin
            ByteIn = stim[sent];
            case (mode)
                0: ByteValid = 1'b1;
                1: begin
                    ByteValid = phase;
                    phase = ~phase;
                end
                default: begin
                    ByteValid = 1'($urandom_range(0, 1));
                    Start = ($urandom_range(0, 3) == 0);
                    WordCount = CW'($urandom_range(0, 63));
                end
            endcase
            acc = ByteValid && ByteReady;
            step();
            if (acc) sent++;
            guard++;
            if (guard > count * 8 + 50) begin
                check("stream_timeout", 64'(sent), 64'(count));
                break;
            end
        end
        ByteValid = 1'b0;
        Start = 1'b0;
    endtask

    // stop < 0: complete load; otherwise return after 'stop' accepted bytes, mid-COLLECT.
    task automatic run_load(input int n, input int mode, input int stop, input bit fixed);
        int words = (n > DEPTH) ? DEPTH : n;
        int total = 4 * words;
        int complete = (stop < 0) ? words : stop / 4;
        int p0 = pulse_cnt;
        int c;
        stim.delete();
        for (int i = 0; i < total; i++)
            stim.push_back(fixed ? fixed_bytes[i % 8] : 8'($urandom_range(0, 255)));
        for (int i = 0; i < complete; i++)
            exp_q.push_back({CW'(i), stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]});
        do_start(n);
        count_busy_reset(words > 0, c);
        check(words > 0 ? "prep_cycles" : "prep_flush_cycles", 64'(c), words > 0 ? 64'd2 : 64'd4);
        if (words > 0) stream((stop < 0) ? total : stop, mode);
        if (stop < 0) begin
            if (words > 0) begin
                count_busy_reset(1'b0, c);
                check("flush_cycles", 64'(c), 64'd2);
            end
            check("run_outputs", 64'({Done, CPUReset, Busy}), 64'b100);
        end
        check("pulse_count", 64'(pulse_cnt - p0), 64'(complete));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int p0;
        repeat (3) step();
        check_reset_vals("reset");
        Reset_n = 1'b1;
        step();
        check_reset_vals("idle");

        run_load(2, 0, -1, 1'b1);
        run_load(2, 1, -1, 1'b1);
        run_load(0, 0, -1, 1'b0);
        run_load(40, 2, -1, 1'b0);

        // Abort two bytes into word 1, with a byte offered in the same cycle.
        run_load(3, 0, 6, 1'b0);
        p0 = pulse_cnt;
        Abort = 1'b1;
        ByteValid = 1'b1;
        ByteIn = 8'hEE;
        step();
        Abort = 1'b0;
        ByteValid = 1'b0;
        check("abort_state", 64'({CPUReset, Busy, Done, ByteReady}), 64'b1000);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        repeat (2) step();
        check("abort_idle_hold", 64'({CPUReset, Busy, Done}), 64'b100);
        check("abort_no_pulse", 64'(pulse_cnt - p0), 64'd0);
        run_load(2, 2, -1, 1'b0);

        Abort = 1'b1;
        step();
        Abort = 1'b0;
        step();
        check("abort_ignored_run", 64'({Done, CPUReset}), 64'b10);

        // Asynchronous reset mid-COLLECT, sampled before the next clock edge.
        run_load(3, 1, 5, 1'b0);
        p0 = pulse_cnt;
        #2 Reset_n = 1'b0;
        #1 check_reset_vals("rst_collect");
        repeat (2) step();
        Reset_n = 1'b1;
        repeat (4) step();
        check("rst_collect_no_pulse", 64'(pulse_cnt - p0), 64'd0);

        // Reset during FLUSH.
        begin
            int c;
            stim.delete();
            for (int i = 0; i < 4; i++) stim.push_back(8'($urandom_range(0, 255)));
            exp_q.push_back({CW'(0), stim[0], stim[1], stim[2], stim[3]});
            p0 = pulse_cnt;
            do_start(1);
            count_busy_reset(1'b1, c);
            check("prep_cycles", 64'(c), 64'd2);
            stream(4, 0);
            step();
            check("flush_state", 64'({CPUReset, Busy, Done}), 64'b110);
            #2 Reset_n = 1'b0;
            #1 check_reset_vals("rst_flush");
            step();
            Reset_n = 1'b1;
            repeat (3) step();
            check("rst_flush_pulses", 64'(pulse_cnt - p0), 64'd1);
            check("rst_flush_idle", 64'({CPUReset, Done}), 64'b10);
        end

        run_load(1, 0, -1, 1'b0);
        for (int k = 0; k < 4; k++) run_load($urandom_range(1, 8), 2, -1, 1'b0);

        repeat (3) step();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
